mmio_port_bank: RTL and testbench

Parametrised memory-mapped I/O bank for the p18240 datapath. It generalises the single fixed switch/LED location into NCH independent input and output channels at a configurable base address. It also adds input synchronisation, sticky change-detect status with read-to-clear, and an optional masked interrupt. It sits on the memory side of the datapath: it watches the MAR address and the re_L/we_L control points, and drives or samples dataBus.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_in_sync.sv | 30 +++
 rtl/tridrive.sv | 12 +
 rtl/mmio_port_bank.sv | 107 ++++++++++
 tb/tb_mmio_port_bank.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped port bank: default window base and
// register offsets within the window, which depend on the channel count.
package mmio_pkg;

    localparam logic [15:0] DEFAULT_BASE = 16'h2000;

    function automatic logic [15:0] OFF_STATUS(input int nch);
        return 16'(nch);
    endfunction

    function automatic logic [15:0] OFF_MASK(input int nch);
        return 16'(nch + 1);
    endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// Per-channel input conditioning: two-flop synchroniser plus a previous-value
// register, so a change shows up as sync != prev for exactly one cycle.
module mmio_in_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] sync,
    output logic             changed
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= asyncIn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign changed = (sync != prev);

endmodule

// File: rtl/tridrive.sv
// Tri-state bus driver: puts data on the bus while enable is high, high-Z otherwise.
module tridrive #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    output tri   [WIDTH-1:0] bus
);

    assign bus = enable ? data : 'z;

endmodule

// File: rtl/mmio_port_bank.sv
// NCH-channel memory-mapped I/O bank with sticky change status (read-to-clear).
// Define MMIO_IRQ_EN to add the MASK register and a registered masked interrupt.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int          NCH   = 4,
    parameter logic [15:0] BASE  = DEFAULT_BASE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          memAddr,
    input  logic                 re_L,
    input  logic                 we_L,
    inout  wire  [WIDTH-1:0]     dataBus,
    input  logic [NCH*WIDTH-1:0] chIn,
    output logic [NCH*WIDTH-1:0] chOut,
    output logic                 hit,
    output logic                 irq
);

    logic [15:0]      offset;
    logic             isData;
    logic             isStatus;
    logic             isMask;
    logic             readEn;
    logic             writeEn;
    logic [WIDTH-1:0] syncVal [NCH];
    logic [NCH-1:0]   changed;
    logic [NCH-1:0]   status;
    logic [NCH-1:0]   statusClr;
    logic [WIDTH-1:0] readData;
`ifdef MMIO_IRQ_EN
    logic [NCH-1:0]   mask;
`endif

    // Addresses below BASE wrap to large offsets and so fall outside the window.
    assign offset   = memAddr - BASE;
    assign isData   = (offset < 16'(NCH));
    assign isStatus = (offset == OFF_STATUS(NCH));
    assign hit      = isData || isStatus || isMask;

    // A simultaneous read and write is treated as a write only.
    assign readEn  = hit && !re_L && we_L && !reset;
    assign writeEn = hit && !we_L;

    for (genvar i = 0; i < NCH; i++) begin : gChannel
        mmio_in_sync #(.WIDTH(WIDTH)) inSync (
            .clock   (clock),
            .reset   (reset),
            .asyncIn (chIn[i*WIDTH +: WIDTH]),
            .sync    (syncVal[i]),
            .changed (changed[i])
        );
    end

    always_comb begin
        readData = '0;
        for (int i = 0; i < NCH; i++) begin
            if (isData && offset == 16'(i)) readData = syncVal[i];
        end
        if (isStatus) readData[NCH-1:0] = status;
`ifdef MMIO_IRQ_EN
        if (isMask) readData[NCH-1:0] = mask;
`endif
    end

    // Only flags actually returned by a STATUS read are cleared; new changes win.
    assign statusClr = (readEn && isStatus) ? status : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            chOut  <= '0;
            status <= '0;
        end else begin
            status <= (status & ~statusClr) | changed;
            for (int i = 0; i < NCH; i++) begin
                if (writeEn && isData && offset == 16'(i))
                    chOut[i*WIDTH +: WIDTH] <= dataBus;
            end
        end
    end

`ifdef MMIO_IRQ_EN
    assign isMask = (offset == OFF_MASK(NCH));

    always_ff @(posedge clock) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (writeEn && isMask) mask <= dataBus[NCH-1:0];
            irq <= |(status & mask);
        end
    end
`else
    assign isMask = 1'b0;
    assign irq    = 1'b0;
`endif

    tridrive #(.WIDTH(WIDTH)) busDrive (
        .data   (readData),
        .enable (readEn),
        .bus    (dataBus)
    );

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank (WIDTH=16, NCH=4, BASE=16'h2000).
// The bus has a pull-up, so an undriven bus reads as 16'hFFFF.
module tb_mmio_port_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    tri   [15:0] dataBus;
    logic [63:0] chIn;
    logic [63:0] chOut;
    logic        hit;
    logic        irq;

    logic [15:0] tbDrive;
    logic        tbDriveEn;

    int compared;
    int mismatched;

    always #5 clock = ~clock;

    assign dataBus = tbDriveEn ? tbDrive : 'z;

    for (genvar b = 0; b < 16; b++) begin : gPull
        pullup (dataBus[b]);
    end

    mmio_port_bank dut (
        .clock   (clock),
        .reset   (reset),
        .memAddr (memAddr),
        .re_L    (re_L),
        .we_L    (we_L),
        .dataBus (dataBus),
        .chIn    (chIn),
        .chOut   (chOut),
        .hit     (hit),
        .irq     (irq)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic re, input logic we,
                                 input logic drv, input logic [15:0] val);
        memAddr   = addr;
        re_L      = re;
        we_L      = we;
        tbDriveEn = drv;
        tbDrive   = val;
    endtask

    task automatic idleBus();
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; checks the read value mid-cycle.
    task automatic readCheck(input string tag, input logic [15:0] addr, input logic [15:0] expected);
        applyStimulus(addr, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clock);
        checkOutput(tag, {48'h0, dataBus}, {48'h0, expected});
        nextCycle();
        idleBus();
    endtask

    task automatic writeBus(input logic [15:0] addr, input logic [15:0] val);
        applyStimulus(addr, 1'b1, 1'b0, 1'b1, val);
        nextCycle();
        idleBus();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        chIn       = {4{16'hFFFF}};
        idleBus();

        // Reset held for two edges while a STATUS read is attempted
        applyStimulus(16'h2004, 1'b0, 1'b1, 1'b0, 16'h0000);
        nextCycle();
        @(negedge clock);
        checkOutput("resetChOut", chOut, 64'h0);
        checkOutput("resetIrq", {63'h0, irq}, 64'h0);
        checkOutput("resetNoDrive", {48'h0, dataBus}, {48'h0, 16'hFFFF});
        checkOutput("resetHit", {63'h0, hit}, 64'h1);
        nextCycle();
        reset = 1'b0;
        idleBus();

        // All inputs were FFFF during reset: every flag sets three edges after release
        nextCycle();
        nextCycle();
        nextCycle();
        readCheck("statusAfterReset", 16'h2004, 16'h000F);
        readCheck("statusCleared", 16'h2004, 16'h0000);

        // ch0 FFFF->0000, ch2 FFFF->3C3C
        chIn = {16'hFFFF, 16'h3C3C, 16'hFFFF, 16'h0000};
        nextCycle();
        nextCycle();
        nextCycle();
        readCheck("statusCh0Ch2", 16'h2004, 16'h0005);

        // Write channel 2 output, visible only after the edge
        applyStimulus(16'h2002, 1'b1, 1'b0, 1'b1, 16'hA5A5);
        @(negedge clock);
        checkOutput("writeNotYet", chOut, 64'h0);
        nextCycle();
        idleBus();
        @(negedge clock);
        checkOutput("writeCh2", chOut, 64'h0000_A5A5_0000_0000);
        nextCycle();
        readCheck("readCh2Input", 16'h2002, 16'h3C3C);

        // Input latency: ch0 0000->1234 just after edge k
        chIn[15:0] = 16'h1234;
        nextCycle();
        readCheck("latencyK1", 16'h2000, 16'h0000);
        readCheck("latencyK2", 16'h2000, 16'h1234);
        readCheck("latencyStatusK3", 16'h2004, 16'h0001);

        // Read-clear race: ch1 change lands on the edge ending the STATUS read
        chIn[15:0] = 16'h5678;
        nextCycle();
        chIn[31:16] = 16'h0000;
        nextCycle();
        nextCycle();
        readCheck("raceFirstRead", 16'h2004, 16'h0001);
        readCheck("raceSecondRead", 16'h2004, 16'h0002);
        readCheck("raceThirdRead", 16'h2004, 16'h0000);

        // Unmapped offsets: no hit, no drive, no register change
        applyStimulus(16'h2006, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clock);
        checkOutput("unmappedHit", {63'h0, hit}, 64'h0);
        checkOutput("unmappedNoDrive", {48'h0, dataBus}, {48'h0, 16'hFFFF});
        nextCycle();
        writeBus(16'h2006, 16'h1111);
        applyStimulus(16'h1FFF, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clock);
        checkOutput("belowBaseHit", {63'h0, hit}, 64'h0);
        checkOutput("belowBaseNoDrive", {48'h0, dataBus}, {48'h0, 16'hFFFF});
        checkOutput("unmappedChOut", chOut, 64'h0000_A5A5_0000_0000);
        checkOutput("unmappedIrq", {63'h0, irq}, 64'h0);
        nextCycle();
        idleBus();
`ifndef MMIO_IRQ_EN
        applyStimulus(16'h2005, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clock);
        checkOutput("noMaskHit", {63'h0, hit}, 64'h0);
        checkOutput("noMaskNoDrive", {48'h0, dataBus}, {48'h0, 16'hFFFF});
        nextCycle();
        idleBus();
`endif

        // STATUS is read-only
        writeBus(16'h2004, 16'hFFFF);
        readCheck("statusWriteIgnored", 16'h2004, 16'h0000);

        // Both strobes low: the write still happens
        applyStimulus(16'h2001, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        nextCycle();
        idleBus();
        @(negedge clock);
        checkOutput("bothStrobesWrite", chOut, 64'h0000_A5A5_BEEF_0000);
        nextCycle();

`ifdef MMIO_IRQ_EN
        writeBus(16'h2005, 16'h0004);
        readCheck("maskReadback", 16'h2005, 16'h0004);
        chIn[47:32] = 16'hC3C3;
        nextCycle();
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("irqK3", {63'h0, irq}, 64'h0);
        nextCycle();
        applyStimulus(16'h2004, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clock);
        checkOutput("irqK4", {63'h0, irq}, 64'h1);
        checkOutput("irqStatusRead", {48'h0, dataBus}, {48'h0, 16'h0004});
        nextCycle();
        idleBus();
        @(negedge clock);
        checkOutput("irqAtClear", {63'h0, irq}, 64'h1);
        nextCycle();
        @(negedge clock);
        checkOutput("irqAfterClear", {63'h0, irq}, 64'h0);
        nextCycle();
        chIn[15:0] = 16'h0000;
        for (int i = 0; i < 6; i++) nextCycle();
        @(negedge clock);
        checkOutput("irqMaskedCh0", {63'h0, irq}, 64'h0);
        nextCycle();
        readCheck("maskedStatus", 16'h2004, 16'h0001);
`endif

        // Reset during a write suppresses it
        applyStimulus(16'h2003, 1'b1, 1'b0, 1'b1, 16'h7777);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        idleBus();
        @(negedge clock);
        checkOutput("resetMidWrite", chOut, 64'h0);
        checkOutput("resetMidWriteIrq", {63'h0, irq}, 64'h0);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
